key_conditioner: RTL

- Upstream conditioning stage between the board push-buttons (KEY[3:0], active-low, bouncy, asynchronous) and door_lock_top.
- Per button: synchronises to i_clk, debounces, and produces a clean held level plus a single-cycle press pulse.
- door_lock_top's confirm, switch and hard-reset inputs are fed from these pulses and levels instead of raw ~KEY.

---
 rtl/key_conditioner_pkg.sv | 26 ++
 rtl/key_conditioner_if.sv | 23 ++
 rtl/key_debounce_channel.sv | 130 +++++++++++++
 rtl/key_conditioner.sv | 40 ++++
 4 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared constants, width helper and per-channel state encoding for the
// key conditioner.
package key_cond_pkg;

  // 20 ms debounce and 2 s long-press at 50 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned LONG_CYCLES_DEFAULT     = 100000000;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int unsigned clog2_w(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_conditioner_if.sv
// Button bundle: raw active-low keys in, conditioned levels and pulses out.
// W is the number of channels carried.
interface key_conditioner_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] key_n;
  logic [W-1:0] level;
  logic [W-1:0] press;
  logic [W-1:0] rel;
  logic [W-1:0] long_press;

  // Side driving the raw keys and consuming the conditioned outputs.
  modport master (
    output key_n,
    input  level, press, rel, long_press
  );

  // Conditioning side.
  modport slave (
    input  key_n,
    output level, press, rel, long_press
  );
endinterface

// File: rtl/key_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM with counter,
// registered level and press/release pulses.
// Optional hold counter for long-press pulses: KEY_COND_LONG_PRESS_EN.
module key_debounce_channel
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  key_conditioner_if.slave  bus
);

  localparam int unsigned   CW       = clog2_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] cnt;
  key_state_e    state;

  assign s = sync[1];

  // Bring the asynchronous raw key into the clock domain; idle is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= '1;
    else          sync <= {sync[0], bus.key_n[0]};
  end

  // Debounce FSM: a pending state survives only while s keeps differing
  // from the stable value; acceptance updates level and fires a pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= RELEASED;
      cnt          <= '0;
      bus.level[0] <= 1'b0;
      bus.press[0] <= 1'b0;
      bus.rel[0]   <= 1'b0;
    end else begin
      bus.press[0] <= 1'b0;
      bus.rel[0]   <= 1'b0;
      case (state)
        RELEASED: begin
          if (!s) begin
            state <= PRESS_PENDING;
            cnt   <= CW'(1);
          end else begin
            cnt   <= '0;
          end
        end
        PRESS_PENDING: begin
          if (s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state        <= PRESSED;
            cnt          <= '0;
            bus.level[0] <= 1'b1;
            bus.press[0] <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (s) begin
            state <= RELEASE_PENDING;
            cnt   <= CW'(1);
          end else begin
            cnt   <= '0;
          end
        end
        RELEASE_PENDING: begin
          if (!s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state        <= RELEASED;
            cnt          <= '0;
            bus.level[0] <= 1'b0;
            bus.rel[0]   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_COND_LONG_PRESS_EN
  localparam int unsigned   HW        = clog2_w(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold;
  logic          fired;

  // Count debounced hold time; pulse once when it expires, then freeze
  // until the key is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold              <= '0;
      fired             <= 1'b0;
      bus.long_press[0] <= 1'b0;
    end else begin
      bus.long_press[0] <= 1'b0;
      if (bus.level[0]) begin
        if (!fired) begin
          if (hold == HOLD_LAST) begin
            bus.long_press[0] <= 1'b1;
            fired             <= 1'b1;
          end else begin
            hold <= hold + HW'(1);
          end
        end
      end else begin
        hold  <= '0;
        fired <= 1'b0;
      end
    end
  end
`else
  // Feature compiled out; LONG_CYCLES only kept so overrides stay legal.
  assign bus.long_press[0] = 1'b0 & (LONG_CYCLES == 0);
`endif

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw active-low push-buttons into debounced levels and
// single-cycle press/release (and optional long-press) pulses.
// Optional long-press support: KEY_COND_LONG_PRESS_EN.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key_n,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long_press
);

  // Independent channels: no priority, no masking between keys.
  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_conditioner_if #(.W(1)) ch_bus ();

    assign ch_bus.key_n[0] = i_key_n[g];
    assign o_level[g]      = ch_bus.level[0];
    assign o_press[g]      = ch_bus.press[0];
    assign o_release[g]    = ch_bus.rel[0];
    assign o_long_press[g] = ch_bus.long_press[0];

    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (ch_bus.slave)
    );
  end

endmodule
